// File: rtl/ad9837_spi_responder_if.sv
// Three-wire AD9837 serial write bus: frame select, serial clock and data.
// The initiator drives all three lines; the responder only observes them.
`timescale 1ns/1ps
interface ad9837_spi_responder_if;
  logic fsync_i;
  logic sclk_i;
  logic sdata_i;

  modport master (output fsync_i, sclk_i, sdata_i);
  modport slave  (input  fsync_i, sclk_i, sdata_i);
endinterface

// File: rtl/ad9837_spi_responder.sv
// AD9837 serial-write responder: oversamples FSYNC/SCLK/SDATA in the clk_i domain,
// deframes 16-bit words and mirrors the part's control, frequency and phase registers.
`timescale 1ns/1ps
module ad9837_spi_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  ad9837_spi_responder_if.slave spi,
  output logic [15:0]           word_o,
  output logic                  word_valid_o,
  output logic                  update_o,
  output logic                  frame_err_o,
  output logic                  busy_o,
  output logic [15:0]           ctrl_o,
  output logic [27:0]           freq0_o,
  output logic [27:0]           freq1_o,
  output logic [11:0]           phase0_o,
  output logic [11:0]           phase1_o
);

  typedef enum logic {IDLE, FRAME} state_t;
  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] fsync_sync, sclk_sync, sdata_sync, settle;
  logic        fsync_s, sclk_s, sdata_s, fsync_d, sclk_d, armed;
  logic        fsync_fall, fsync_rise, sclk_fall, bit_take, word_done;
  logic [3:0]  cnt, cnt_base;
  logic [14:0] shift, shift_base;
  logic [15:0] word_p0;
  logic        vld_p0, err_p0;
  logic        pend, pend_n, pend_sel, pend_sel_n, upd_n, f_commit;
  logic [13:0] staged, staged_n, payload;
  logic [15:0] ctrl_n;
  logic [27:0] freq0_n, freq1_n, f_cur, f_new;
  logic [11:0] phase0_n, phase1_n;

  // Input synchronizers; the settle chain marks when they hold real samples, so
  // the idle-high reset value is never mistaken for a genuine FSYNC level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fsync_sync <= '1;
      sclk_sync  <= '1;
      sdata_sync <= '0;
      settle     <= '0;
      fsync_d    <= 1'b1;
      sclk_d     <= 1'b1;
      armed      <= 1'b0;
    end else begin
      fsync_sync <= {fsync_sync[SYNC_STAGES-2:0], spi.fsync_i};
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk_i};
      sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], spi.sdata_i};
      settle     <= {settle[SYNC_STAGES-2:0], 1'b1};
      fsync_d    <= fsync_s;
      sclk_d     <= sclk_s;
      armed      <= armed | (settle[SYNC_STAGES-1] & fsync_s);
    end
  end

  assign fsync_s    = fsync_sync[SYNC_STAGES-1];
  assign sclk_s     = sclk_sync[SYNC_STAGES-1];
  assign sdata_s    = sdata_sync[SYNC_STAGES-1];
  assign busy_o     = ~fsync_s;
  assign fsync_fall = armed & fsync_d & ~fsync_s;
  assign fsync_rise = ~fsync_d & fsync_s;
  assign sclk_fall  = sclk_d & ~sclk_s;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fsync_fall) state_nxt = FRAME;
      FRAME:   if (fsync_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign cnt_base   = fsync_fall ? 4'd0 : cnt;
  assign shift_base = fsync_fall ? 15'd0 : shift;
  assign bit_take   = sclk_fall & ~fsync_s & ((state == FRAME) | fsync_fall);
  assign word_done  = bit_take & (cnt_base == 4'd15);

  // Stage p0: deframe bits into the shift register, capture completed words.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt    <= '0;
      shift  <= '0;
      vld_p0 <= 1'b0;
      err_p0 <= 1'b0;
    end else begin
      if (bit_take) begin
        shift <= {shift_base[13:0], sdata_s};
        cnt   <= cnt_base + 4'd1;
      end else if (fsync_fall) begin
        shift <= '0;
        cnt   <= '0;
      end
      vld_p0 <= word_done;
      err_p0 <= (state == FRAME) & fsync_rise & (cnt != 4'd0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (word_done) word_p0 <= {shift_base, sdata_s};
    staged <= staged_n;
  end

  assign payload = word_p0[13:0];
  assign f_cur   = word_p0[15] ? freq1_o : freq0_o;

  always_comb begin
    ctrl_n     = ctrl_o;
    freq0_n    = freq0_o;
    freq1_n    = freq1_o;
    phase0_n   = phase0_o;
    phase1_n   = phase1_o;
    pend_n     = pend;
    pend_sel_n = pend_sel;
    staged_n   = staged;
    upd_n      = 1'b0;
    f_new      = f_cur;
    f_commit   = 1'b0;
    if (vld_p0) begin
      case (word_p0[15:14])
        2'b00: begin
          ctrl_n = {2'b00, word_p0[13:0]};
          upd_n  = 1'b1;
          pend_n = 1'b0;
        end
        2'b01, 2'b10: begin
          if (!ctrl_o[13]) begin
            f_commit = 1'b1;
            f_new    = ctrl_o[12] ? {payload, f_cur[13:0]} : {f_cur[27:14], payload};
          end else if (pend && (pend_sel == word_p0[15])) begin
            f_commit = 1'b1;
            f_new    = {payload, staged};
            pend_n   = 1'b0;
          end else begin
            // B28 mode: first half of a pair, or a switch to the other register.
            staged_n   = payload;
            pend_n     = 1'b1;
            pend_sel_n = word_p0[15];
          end
          if (f_commit) begin
            upd_n = 1'b1;
            if (word_p0[15]) freq1_n = f_new;
            else             freq0_n = f_new;
          end
        end
        default: begin
          if (word_p0[13]) phase1_n = word_p0[11:0];
          else             phase0_n = word_p0[11:0];
          upd_n  = 1'b1;
          pend_n = 1'b0;
        end
      endcase
    end
  end

  // Stage p1: register file and output pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_o       <= '0;
      word_valid_o <= 1'b0;
      update_o     <= 1'b0;
      frame_err_o  <= 1'b0;
      ctrl_o       <= '0;
      freq0_o      <= '0;
      freq1_o      <= '0;
      phase0_o     <= '0;
      phase1_o     <= '0;
      pend         <= 1'b0;
      pend_sel     <= 1'b0;
    end else begin
      if (vld_p0) word_o <= word_p0;
      word_valid_o <= vld_p0;
      update_o     <= upd_n;
      frame_err_o  <= err_p0;
      ctrl_o       <= ctrl_n;
      freq0_o      <= freq0_n;
      freq1_o      <= freq1_n;
      phase0_o     <= phase0_n;
      phase1_o     <= phase1_n;
      pend         <= pend_n;
      pend_sel     <= pend_sel_n;
    end
  end

endmodule

// File: tb/tb_ad9837_spi_responder.sv
// Directed bench for ad9837_spi_responder: table of serial words with expected
// register images, plus hand-written latency, partial-frame and reset sequences.
`timescale 1ns/1ps
module tb_ad9837_spi_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] word_o, ctrl_o;
  logic        word_valid_o, update_o, frame_err_o, busy_o;
  logic [27:0] freq0_o, freq1_o;
  logic [11:0] phase0_o, phase1_o;

  ad9837_spi_responder_if spi();

  ad9837_spi_responder #(.SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst), .spi(spi.slave),
    .word_o(word_o), .word_valid_o(word_valid_o), .update_o(update_o),
    .frame_err_o(frame_err_o), .busy_o(busy_o), .ctrl_o(ctrl_o),
    .freq0_o(freq0_o), .freq1_o(freq1_o), .phase0_o(phase0_o), .phase1_o(phase1_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wv_cnt = 0, upd_cnt = 0, err_cnt = 0;

  always @(negedge clk) begin
    if (word_valid_o) wv_cnt++;
    if (update_o)     upd_cnt++;
    if (frame_err_o)  err_cnt++;
  end

  typedef struct {
    logic [15:0] w;
    bit          open;
    bit          close;
    logic [15:0] ctrl;
    logic [27:0] f0;
    logic [27:0] f1;
    logic [11:0] p0;
    logic [11:0] p1;
    int          upd;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic open_frame();
    spi.fsync_i = 1'b0;
    wait_clk(4);
  endtask

  // Sends the top nbits of w MSB first; with close, the final SCLK rise and the
  // FSYNC rise happen together, as a normal initiator ends a frame.
  task automatic send_bits(input logic [15:0] w, input int nbits, input bit close);
    for (int i = 0; i < nbits; i++) begin
      spi.sdata_i = w[15-i];
      wait_clk(2);
      spi.sclk_i = 1'b0;
      wait_clk(4);
      spi.sclk_i = 1'b1;
      if (close && i == nbits - 1) spi.fsync_i = 1'b1;
      wait_clk(2);
    end
    if (close) wait_clk(6);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int wv0, up0, er0;
    vec_t v;

    vt[0]  = '{16'h2100, 1, 0, 16'h2100, 28'h0,       28'h0,       12'h0, 12'h0, 1};
    vt[1]  = '{16'h4CCC, 0, 0, 16'h2100, 28'h0,       28'h0,       12'h0, 12'h0, 0};
    vt[2]  = '{16'h4333, 0, 0, 16'h2100, 28'h0CCCCCC, 28'h0,       12'h0, 12'h0, 1};
    vt[3]  = '{16'hC000, 0, 0, 16'h2100, 28'h0CCCCCC, 28'h0,       12'h0, 12'h0, 1};
    vt[4]  = '{16'h2000, 0, 1, 16'h2000, 28'h0CCCCCC, 28'h0,       12'h0, 12'h0, 1};
    vt[5]  = '{16'h1000, 1, 1, 16'h1000, 28'h0CCCCCC, 28'h0,       12'h0, 12'h0, 1};
    vt[6]  = '{16'h8123, 1, 1, 16'h1000, 28'h0CCCCCC, 28'h048C000, 12'h0, 12'h0, 1};
    vt[7]  = '{16'h0000, 1, 1, 16'h0000, 28'h0CCCCCC, 28'h048C000, 12'h0, 12'h0, 1};
    vt[8]  = '{16'h8055, 1, 1, 16'h0000, 28'h0CCCCCC, 28'h048C055, 12'h0, 12'h0, 1};
    vt[9]  = '{16'h2000, 1, 1, 16'h2000, 28'h0CCCCCC, 28'h048C055, 12'h0, 12'h0, 1};
    vt[10] = '{16'h4001, 1, 1, 16'h2000, 28'h0CCCCCC, 28'h048C055, 12'h0, 12'h0, 0};
    vt[11] = '{16'h8002, 1, 1, 16'h2000, 28'h0CCCCCC, 28'h048C055, 12'h0, 12'h0, 0};
    vt[12] = '{16'h8003, 1, 1, 16'h2000, 28'h0CCCCCC, 28'h000C002, 12'h0, 12'h0, 1};

    spi.fsync_i = 1'b1;
    spi.sclk_i  = 1'b1;
    spi.sdata_i = 1'b0;
    wait_clk(4);
    chk("reset word",   {16'h0, word_o}, 32'h0);
    chk("reset pulses", {29'h0, word_valid_o, update_o, frame_err_o}, 32'h0);
    chk("reset busy",   {31'h0, busy_o}, 32'h0);
    chk("reset ctrl",   {16'h0, ctrl_o}, 32'h0);
    chk("reset freq",   {4'h0, freq0_o | freq1_o}, 32'h0);
    chk("reset phase",  {20'h0, phase0_o | phase1_o}, 32'h0);
    rst = 1'b0;
    wait_clk(10);

    for (int i = 0; i < 13; i++) begin
      v = vt[i];
      if (v.open) open_frame();
      wv0 = wv_cnt;
      up0 = upd_cnt;
      send_bits(v.w, 16, v.close);
      chk($sformatf("v%0d word", i),   {16'h0, word_o}, {16'h0, v.w});
      chk($sformatf("v%0d valid", i),  wv_cnt - wv0, 1);
      chk($sformatf("v%0d update", i), upd_cnt - up0, v.upd);
      chk($sformatf("v%0d ctrl", i),   {16'h0, ctrl_o}, {16'h0, v.ctrl});
      chk($sformatf("v%0d freq0", i),  {4'h0, freq0_o}, {4'h0, v.f0});
      chk($sformatf("v%0d freq1", i),  {4'h0, freq1_o}, {4'h0, v.f1});
      chk($sformatf("v%0d phase0", i), {20'h0, phase0_o}, {20'h0, v.p0});
      chk($sformatf("v%0d phase1", i), {20'h0, phase1_o}, {20'h0, v.p1});
    end

    // 0xEABC: exact latency of word_valid_o and update_o from the 16th SCLK fall.
    open_frame();
    send_bits(16'hEABC, 15, 0);
    spi.sdata_i = 1'b0;
    wait_clk(2);
    spi.sclk_i = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("lat valid e%0d", k),  {31'h0, word_valid_o}, (k == 4) ? 32'h1 : 32'h0);
      chk($sformatf("lat update e%0d", k), {31'h0, update_o},     (k == 4) ? 32'h1 : 32'h0);
    end
    chk("phase1 ABC", {20'h0, phase1_o}, 32'hABC);
    @(negedge clk);
    spi.sclk_i  = 1'b1;
    spi.fsync_i = 1'b1;
    wait_clk(8);

    // busy_o follows FSYNC after two synchronizer edges; then 0xD000.
    spi.fsync_i = 1'b0;
    @(posedge clk);
    #1;
    chk("busy after 1 edge", {31'h0, busy_o}, 32'h0);
    @(posedge clk);
    #1;
    chk("busy after 2 edges", {31'h0, busy_o}, 32'h1);
    wait_clk(3);
    up0 = upd_cnt;
    send_bits(16'hD000, 16, 1);
    chk("D000 word",   {16'h0, word_o}, 32'hD000);
    chk("D000 phase0", {20'h0, phase0_o}, 32'h0);
    chk("D000 phase1", {20'h0, phase1_o}, 32'hABC);
    chk("D000 update", upd_cnt - up0, 1);
    chk("busy idle",   {31'h0, busy_o}, 32'h0);

    // Partial frame of 9 bits, then a good word.
    open_frame();
    wv0 = wv_cnt;
    er0 = err_cnt;
    up0 = upd_cnt;
    send_bits(16'h4FFF, 9, 1);
    chk("partial err",    err_cnt - er0, 1);
    chk("partial valid",  wv_cnt - wv0, 0);
    chk("partial update", upd_cnt - up0, 0);
    chk("partial freq0",  {4'h0, freq0_o}, 32'h0CCCCCC);
    open_frame();
    send_bits(16'h2000, 16, 1);
    chk("after partial valid", wv_cnt - wv0, 1);
    chk("after partial err",   err_cnt - er0, 1);
    chk("after partial word",  {16'h0, word_o}, 32'h2000);
    chk("after partial ctrl",  {16'h0, ctrl_o}, 32'h2000);

    // Asynchronous reset in the middle of a word.
    open_frame();
    send_bits(16'hC7FF, 7, 0);
    #3;
    rst = 1'b1;
    #1;
    chk("mid rst ctrl",  {16'h0, ctrl_o}, 32'h0);
    chk("mid rst freq0", {4'h0, freq0_o}, 32'h0);
    chk("mid rst freq1", {4'h0, freq1_o}, 32'h0);
    chk("mid rst phase1", {20'h0, phase1_o}, 32'h0);
    chk("mid rst word",  {16'h0, word_o}, 32'h0);
    chk("mid rst busy",  {31'h0, busy_o}, 32'h0);
    wait_clk(3);
    rst = 1'b0;
    wv0 = wv_cnt;
    er0 = err_cnt;
    send_bits(16'hFF80, 9, 1);
    chk("post rst ignored valid", wv_cnt - wv0, 0);
    chk("post rst ignored err",   err_cnt - er0, 0);
    wait_clk(4);
    open_frame();
    send_bits(16'hC7FF, 16, 1);
    chk("C7FF valid",  wv_cnt - wv0, 1);
    chk("C7FF word",   {16'h0, word_o}, 32'hC7FF);
    chk("C7FF phase0", {20'h0, phase0_o}, 32'h7FF);
    chk("C7FF ctrl",   {16'h0, ctrl_o}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ad9837_spi_responder.md
# ad9837_spi_responder

- Synthesizable receiver for the AD9837 three-wire serial write interface (FSYNC, SCLK, SDATA).
- Oversamples the lines in the `clk_i` domain, deframes 16-bit words and decodes them into the device's control, frequency and phase registers, emulating the chip's register file.
- Sits on the FPGA side, opposite the waveform-generator initializer, for loopback self-test and for monitoring what was actually programmed into the part.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer flops on each serial input (min 2).

Ports:
- clk_i  in  1  system clock; must be ≥ 4× SCLK frequency.
- rst_i  in  1  asynchronous, active-high reset.
- fsync_i  in  1  frame select, active low.
- sclk_i  in  1  serial clock; idles high; data sampled on falling edge.
- sdata_i  in  1  serial data, MSB first.
- word_o  out  16  last complete word received.
- word_valid_o  out  1  one-cycle pulse when `word_o` updates.
- update_o  out  1  one-cycle pulse when any register output changes value or is written.
- frame_err_o  out  1  one-cycle pulse when a frame ends on a non-16-bit boundary.
- busy_o  out  1  synchronized FSYNC is low.
- ctrl_o  out  16  control register image (D15:14 = 00).
- freq0_o  out  28  FREQ0 register.
- freq1_o  out  28  FREQ1 register.
- phase0_o  out  12  PHASE0 register.
- phase1_o  out  12  PHASE1 register.

## Operation
Input sampling:
- `fsync_i`, `sclk_i` and `sdata_i` each pass through identical SYNC_STAGES flop chains, so they stay mutually aligned.
- One further register on synced SCLK provides falling-edge detection.
- A falling edge counts only if synced FSYNC is low in the same cycle.
- A synced FSYNC falling edge clears the 4-bit bit counter and the shift register.

Deframing:
- On each counted edge, shift synced SDATA into the LSB and increment the bit counter.
- At count 15→0 wrap, register the 16-bit word and pulse `word_valid_o`.
- FSYNC may stay low across multiple words; words are back-to-back, with no gap required.
- FSYNC rising with bit counter ≠ 0: discard the partial word and pulse `frame_err_o`. No register is changed.

Decode (on `word_valid_o`; D = word bits):
- D15:14 = 00: `ctrl_o` ← word. The Reset bit (D8) does not clear the frequency or phase registers.
- D15:14 = 01 / 10: FREQ0 / FREQ1 write with 14-bit payload D13:0.
  - `ctrl_o[13]` (B28) = 0: `ctrl_o[12]` (HLB) = 1 loads bits 27:14; HLB = 0 loads bits 13:0; the other half is held.
  - B28 = 1, first write: stage the payload as LSBs, set pending, record the target register; no output change.
  - B28 = 1, next write to the same register: commit {payload, staged} as the full 28 bits and clear pending.
  - B28 = 1, write to the other frequency register while pending: restart staging for that register.
- D15:13 = 110 / 111: `phase0_o` / `phase1_o` ← D11:0; D12 ignored.
- Any non-frequency word clears pending.
- `update_o` pulses in the same cycle as any committed register write, including control writes. It does not pulse for an LSB staging write.

FSM: IDLE (FSYNC high) → FRAME (FSYNC low) → IDLE on FSYNC rise.

## Timing
- Latency: `word_valid_o`, `word_o`, `update_o` and all register outputs change exactly SYNC_STAGES+2 `clk_i` rising edges after the first edge that samples the 16th `sclk_i` falling edge low.
- `frame_err_o`: SYNC_STAGES+2 edges after the first edge sampling `fsync_i` high.
- `busy_o`: SYNC_STAGES edges after the corresponding `fsync_i` transition.
- Simultaneous SCLK rise and FSYNC rise at frame end (normal initiator behaviour) is not an edge and not an error.
- SCLK fall coincident with FSYNC rise is ignored.
- Reset values: all outputs 0; FSM IDLE; pending cleared.
- Reset mid-frame aborts the word; after release, bits are ignored until the next FSYNC falling edge.

## Test plan
- Single frame, FSYNC held low for 80 bits: 0x2100, 0x4CCC, 0x4333, 0xC000, 0x2000 → five `word_valid_o` pulses, `freq0_o` = 0x0CCCCCC, `phase0_o` = 0, `ctrl_o` = 0x2000. No update after 0x4CCC (staging only).
- B28 = 0 path: 0x1000 then 0x8123 → `freq1_o[27:14]` = 0x0123. Then 0x0000 then 0x8055 → `freq1_o[13:0]` = 0x0055, upper half held.
- Phase: 0xEABC → `phase1_o` = 0xABC, `update_o` single pulse; 0xD000 → `phase0_o` = 0x000.
- Partial frame: FSYNC rises after 9 bits → `frame_err_o` pulse, no `word_valid_o`; next full word 0x2000 decodes correctly.
- B28 = 1 interleave: 0x2000, 0x4001, then 0x8002, then 0x8003 → `freq1_o` = {14'h0003, 14'h0002}; `freq0_o` unchanged.
- Async reset asserted mid-word → all outputs 0 immediately; the following complete frame 0xC7FF gives `phase0_o` = 0x7FF.
